// File: rtl/fft_pkg.sv
// Shared FSM encoding, twiddle generator and fixed-point helpers for the radix-2 FFT stage.
// Wide signed intermediates (acc_t) keep every product and sum exact before final rounding and saturation.
package fft_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fft_state_e;

    localparam int ACC_W = 64;
    typedef logic signed [ACC_W-1:0] acc_t;

    // Wr[k] when imag_part=0, Wi[k] (negated sine) when imag_part=1, rounded half away from zero.
    function automatic acc_t twiddle_val(input int k, input int n_points, input int data_width,
                                         input bit imag_part);
        real amp;
        real ang;
        real v;
        int  r;
        amp = (2.0 ** (data_width - 1)) - 1.0;
        ang = 2.0 * 3.14159265358979323846 * real'(k) / real'(n_points);
        if (imag_part)
            v = -$sin(ang) * amp;
        else
            v = $cos(ang) * amp;
        if (v >= 0.0)
            r = $rtoi(v + 0.5);
        else
            r = -$rtoi(0.5 - v);
        return acc_t'(r);
    endfunction

    // Arithmetic right shift with round-half-up (adds half an LSB of the result first).
    function automatic acc_t round_shift(input acc_t v, input int sh);
        acc_t half;
        if (sh <= 0)
            return v;
        half = acc_t'(1) <<< (sh - 1);
        return (v + half) >>> sh;
    endfunction

    // Clamp to the signed range of a w-bit two's complement value.
    function automatic acc_t sat(input acc_t v, input int w);
        acc_t hi;
        acc_t lo;
        hi = (acc_t'(1) <<< (w - 1)) - acc_t'(1);
        lo = -(acc_t'(1) <<< (w - 1));
        if (v > hi)
            return hi;
        if (v < lo)
            return lo;
        return v;
    endfunction

endpackage

// File: rtl/fft_stage_seq_twiddle_rom.sv
// fft_twiddle_rom: combinational twiddle lookup, Wr[k]/Wi[k] for k in 0..N_POINTS/2-1.
// Table entries are constant-function results, so the lookup reduces to a small constant mux.
module fft_twiddle_rom
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = 20,
    parameter int N_POINTS   = 16
) (
    input  logic [$clog2(N_POINTS)-2:0]  k,
    output logic signed [DATA_WIDTH-1:0] wr,
    output logic signed [DATA_WIDTH-1:0] wi
);

    logic signed [DATA_WIDTH-1:0] wr_tbl [N_POINTS/2];
    logic signed [DATA_WIDTH-1:0] wi_tbl [N_POINTS/2];

    for (genvar gi = 0; gi < N_POINTS/2; gi++) begin : g_tbl
        assign wr_tbl[gi] = DATA_WIDTH'(twiddle_val(gi, N_POINTS, DATA_WIDTH, 1'b0));
        assign wi_tbl[gi] = DATA_WIDTH'(twiddle_val(gi, N_POINTS, DATA_WIDTH, 1'b1));
    end

    assign wr = wr_tbl[k];
    assign wi = wi_tbl[k];

endmodule

// File: rtl/fft_stage_seq.sv
// fft_stage_seq: one radix-2 DIT stage, one in-place butterfly per cycle over a captured frame.
// Define FFT_STAGE_SCALE_EN to halve (round-half-up) each butterfly sum/difference before saturation.
module fft_stage_seq
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = 20,
    parameter int N_POINTS   = 16,
    parameter int STAGE      = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DATA_WIDTH*N_POINTS-1:0]   x_in_flat_real,
    input  logic [DATA_WIDTH*N_POINTS-1:0]   x_in_flat_imag,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_WIDTH*N_POINTS-1:0]   x_out_flat_real,
    output logic [DATA_WIDTH*N_POINTS-1:0]   x_out_flat_imag,
    output logic                             busy
);

    localparam int                LOG2N     = $clog2(N_POINTS);
    localparam int                J_W       = LOG2N - 1;
    localparam int                HALF      = N_POINTS / 2;
    localparam logic [J_W-1:0]    J_LAST    = J_W'(HALF - 1);
    localparam logic [J_W-1:0]    SPAN_MASK = J_W'((1 << STAGE) - 1);
    localparam logic [LOG2N-1:0]  SPAN      = LOG2N'(1 << STAGE);
    localparam int                K_SHIFT   = LOG2N - 1 - STAGE;

    fft_state_e                   state_q, state_d;
    logic [J_W-1:0]               j_q, j_d;
    logic signed [DATA_WIDTH-1:0] fb_re_q [N_POINTS];
    logic signed [DATA_WIDTH-1:0] fb_im_q [N_POINTS];
    logic signed [DATA_WIDTH-1:0] fb_re_d [N_POINTS];
    logic signed [DATA_WIDTH-1:0] fb_im_d [N_POINTS];
    logic signed [DATA_WIDTH-1:0] in_re   [N_POINTS];
    logic signed [DATA_WIDTH-1:0] in_im   [N_POINTS];

    logic [LOG2N-1:0]             top_idx, bot_idx;
    logic [J_W-1:0]               tw_k;
    logic signed [DATA_WIDTH-1:0] w_re, w_im;
    logic signed [DATA_WIDTH-1:0] new_top_re, new_top_im, new_bot_re, new_bot_im;

    for (genvar gi = 0; gi < N_POINTS; gi++) begin : g_frame_io
        assign in_re[gi] = x_in_flat_real[DATA_WIDTH*(N_POINTS-gi)-1 -: DATA_WIDTH];
        assign in_im[gi] = x_in_flat_imag[DATA_WIDTH*(N_POINTS-gi)-1 -: DATA_WIDTH];
        assign x_out_flat_real[DATA_WIDTH*(N_POINTS-gi)-1 -: DATA_WIDTH] =
            (state_q == ST_DONE) ? fb_re_q[gi] : '0;
        assign x_out_flat_imag[DATA_WIDTH*(N_POINTS-gi)-1 -: DATA_WIDTH] =
            (state_q == ST_DONE) ? fb_im_q[gi] : '0;
    end

    // Butterfly j pairs top = (j/span)*2*span + j%span with bot = top + span.
    always_comb begin : p_index
        top_idx = (LOG2N'(j_q >> STAGE) << (STAGE + 1)) | LOG2N'(j_q & SPAN_MASK);
        bot_idx = top_idx | SPAN;
        tw_k    = (j_q & SPAN_MASK) << K_SHIFT;
    end

    fft_twiddle_rom #(
        .DATA_WIDTH (DATA_WIDTH),
        .N_POINTS   (N_POINTS)
    ) u_twiddle (
        .k  (tw_k),
        .wr (w_re),
        .wi (w_im)
    );

    always_comb begin : p_butterfly
        acc_t a_re, a_im, b_re, b_im, wr_x, wi_x;
        acc_t t_re, t_im, s_re, s_im, d_re, d_im;
        a_re = acc_t'(fb_re_q[top_idx]);
        a_im = acc_t'(fb_im_q[top_idx]);
        b_re = acc_t'(fb_re_q[bot_idx]);
        b_im = acc_t'(fb_im_q[bot_idx]);
        wr_x = acc_t'(w_re);
        wi_x = acc_t'(w_im);
        t_re = round_shift((wr_x * b_re) - (wi_x * b_im), DATA_WIDTH - 1);
        t_im = round_shift((wr_x * b_im) + (wi_x * b_re), DATA_WIDTH - 1);
        s_re = a_re + t_re;
        s_im = a_im + t_im;
        d_re = a_re - t_re;
        d_im = a_im - t_im;
`ifdef FFT_STAGE_SCALE_EN
        s_re = round_shift(s_re, 1);
        s_im = round_shift(s_im, 1);
        d_re = round_shift(d_re, 1);
        d_im = round_shift(d_im, 1);
`endif
        new_top_re = DATA_WIDTH'(sat(s_re, DATA_WIDTH));
        new_top_im = DATA_WIDTH'(sat(s_im, DATA_WIDTH));
        new_bot_re = DATA_WIDTH'(sat(d_re, DATA_WIDTH));
        new_bot_im = DATA_WIDTH'(sat(d_im, DATA_WIDTH));
    end

    always_comb begin : p_fsm
        state_d = state_q;
        j_d     = j_q;
        fb_re_d = fb_re_q;
        fb_im_d = fb_im_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    fb_re_d = in_re;
                    fb_im_d = in_im;
                    j_d     = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                fb_re_d[top_idx] = new_top_re;
                fb_im_d[top_idx] = new_top_im;
                fb_re_d[bot_idx] = new_bot_re;
                fb_im_d[bot_idx] = new_bot_im;
                j_d              = j_q + 1'b1;
                if (j_q == J_LAST)
                    state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready)
                    state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            j_q     <= '0;
            fb_re_q <= '{default: '0};
            fb_im_q <= '{default: '0};
        end else begin
            state_q <= state_d;
            j_q     <= j_d;
            fb_re_q <= fb_re_d;
            fb_im_q <= fb_im_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_RUN);
    assign out_valid = (state_q == ST_DONE);

endmodule

// File: tb/tb_fft_stage_seq.sv
// Bench for fft_stage_seq: STAGE=0 and STAGE=3 instances share stimulus; a queue holds model results per frame.
module tb_fft_stage_seq;

    localparam int DW     = 20;
    localparam int N      = 16;
    localparam int BW     = DW * N;
    localparam int HALF   = N / 2;
    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_DONE = 2;

    typedef longint frame_t [N];
    typedef struct {
        logic [BW-1:0] r0;
        logic [BW-1:0] i0;
        logic [BW-1:0] r3;
        logic [BW-1:0] i3;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst, in_valid, out_ready;
    logic [BW-1:0] x_re_bus, x_im_bus;
    logic          in_ready0, busy0, out_valid0;
    logic          in_ready3, busy3, out_valid3;
    logic [BW-1:0] o_re0, o_im0, o_re3, o_im3;

    always #5 clk = ~clk;

    fft_stage_seq #(.DATA_WIDTH(DW), .N_POINTS(N), .STAGE(0)) u_dut0 (
        .clk (clk), .rst (rst), .in_valid (in_valid), .in_ready (in_ready0),
        .x_in_flat_real (x_re_bus), .x_in_flat_imag (x_im_bus),
        .out_valid (out_valid0), .out_ready (out_ready),
        .x_out_flat_real (o_re0), .x_out_flat_imag (o_im0), .busy (busy0)
    );

    fft_stage_seq #(.DATA_WIDTH(DW), .N_POINTS(N), .STAGE(3)) u_dut3 (
        .clk (clk), .rst (rst), .in_valid (in_valid), .in_ready (in_ready3),
        .x_in_flat_real (x_re_bus), .x_in_flat_imag (x_im_bus),
        .out_valid (out_valid3), .out_ready (out_ready),
        .x_out_flat_real (o_re3), .x_out_flat_imag (o_im3), .busy (busy3)
    );

    exp_t   sb_q[$];
    int     n_cmp = 0;
    int     n_bad = 0;
    int     cyc = 0;
    int     exp_state = S_IDLE;
    int     exp_cnt = 0;
    int     n_acc = 0;
    int     n_pop = 0;
    int     last_acc_cyc = -1;
    bit     check_spacing = 1'b0;
    frame_t fr_re, fr_im;

    task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic longint rnd_shr(input longint v, input int s);
        longint q;
        longint rem;
        q   = v >>> s;
        rem = v - (q <<< s);
        if (rem >= (longint'(1) <<< (s - 1)))
            q++;
        return q;
    endfunction

    function automatic longint clamp(input longint v);
        longint hi;
        hi = (longint'(1) <<< (DW - 1)) - 1;
        if (v > hi) return hi;
        if (v < -hi - 1) return -hi - 1;
        return v;
    endfunction

    function automatic longint round_real(input real v);
        if (v >= 0.0) return longint'($rtoi(v + 0.5));
        return -longint'($rtoi(0.5 - v));
    endfunction

    function automatic longint get(input logic [BW-1:0] bus, input int i);
        logic signed [DW-1:0] s;
        s = bus[DW*(N-i)-1 -: DW];
        return longint'(s);
    endfunction

    // Reference stage: loop over butterfly groups, twiddle from floating point.
    function automatic void model(input int stage, input frame_t xr, input frame_t xi,
                                  output logic [BW-1:0] obr, output logic [BW-1:0] obi);
        frame_t yr, yi;
        int     span, tp, bt;
        real    amp, ang;
        longint wr, wi, tr, ti, sr, si, dr, di;
        yr   = xr;
        yi   = xi;
        span = 1 << stage;
        amp  = (2.0 ** (DW - 1)) - 1.0;
        for (int blk = 0; blk < N; blk += 2 * span) begin
            for (int m = 0; m < span; m++) begin
                tp  = blk + m;
                bt  = tp + span;
                ang = 2.0 * 3.14159265358979323846 * real'(m * N / (2 * span)) / real'(N);
                wr  = round_real($cos(ang) * amp);
                wi  = -round_real($sin(ang) * amp);
                tr  = rnd_shr(wr * yr[bt] - wi * yi[bt], DW - 1);
                ti  = rnd_shr(wr * yi[bt] + wi * yr[bt], DW - 1);
                sr  = yr[tp] + tr;
                si  = yi[tp] + ti;
                dr  = yr[tp] - tr;
                di  = yi[tp] - ti;
`ifdef FFT_STAGE_SCALE_EN
                sr  = rnd_shr(sr, 1);
                si  = rnd_shr(si, 1);
                dr  = rnd_shr(dr, 1);
                di  = rnd_shr(di, 1);
`endif
                yr[tp] = clamp(sr);
                yi[tp] = clamp(si);
                yr[bt] = clamp(dr);
                yi[bt] = clamp(di);
            end
        end
        obr = '0;
        obi = '0;
        for (int i = 0; i < N; i++) begin
            obr[DW*(N-i)-1 -: DW] = DW'(yr[i]);
            obi[DW*(N-i)-1 -: DW] = DW'(yi[i]);
        end
    endfunction

    task automatic clear_frame();
        for (int i = 0; i < N; i++) begin
            fr_re[i] = 0;
            fr_im[i] = 0;
        end
    endtask

    task automatic rand_frame();
        logic signed [DW-1:0] r;
        for (int i = 0; i < N; i++) begin
            r        = DW'($urandom);
            fr_re[i] = longint'(r);
            r        = DW'($urandom);
            fr_im[i] = longint'(r);
        end
    endtask

    // One clock: predict handshakes, advance, then check status and (in DONE) the result frame.
    task automatic cycle();
        bit   acc, rel, was_rst;
        exp_t e;
        for (int i = 0; i < N; i++) begin
            x_re_bus[DW*(N-i)-1 -: DW] = DW'(fr_re[i]);
            x_im_bus[DW*(N-i)-1 -: DW] = DW'(fr_im[i]);
        end
        was_rst = rst;
        acc     = !rst && exp_state == S_IDLE && in_valid;
        rel     = !rst && exp_state == S_DONE && out_ready;
        if (acc) begin
            model(0, fr_re, fr_im, e.r0, e.i0);
            model(3, fr_re, fr_im, e.r3, e.i3);
            sb_q.push_back(e);
            n_acc++;
            if (check_spacing && last_acc_cyc >= 0)
                check("accept_spacing", cyc + 1 - last_acc_cyc, HALF + 2);
            last_acc_cyc = cyc + 1;
        end
        if (rel && sb_q.size() > 0) begin
            void'(sb_q.pop_front());
            n_pop++;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (was_rst) begin
            exp_state = S_IDLE;
            exp_cnt   = 0;
            sb_q.delete();
        end else begin
            case (exp_state)
                S_IDLE: if (acc) begin exp_state = S_RUN; exp_cnt = 0; end
                S_RUN:  if (exp_cnt == HALF - 1) exp_state = S_DONE; else exp_cnt++;
                default: if (rel) exp_state = S_IDLE;
            endcase
        end
        check("status0", {in_ready0, busy0, out_valid0},
              {exp_state == S_IDLE, exp_state == S_RUN, exp_state == S_DONE});
        check("status3", {in_ready3, busy3, out_valid3},
              {exp_state == S_IDLE, exp_state == S_RUN, exp_state == S_DONE});
        if (was_rst) begin
            check("rst_re0", o_re0, '0);
            check("rst_im0", o_im0, '0);
            check("rst_re3", o_re3, '0);
            check("rst_im3", o_im3, '0);
        end
        if (exp_state == S_DONE) begin
            check("sb_depth", sb_q.size(), 1);
            if (sb_q.size() > 0) begin
                check("out_re0", o_re0, sb_q[0].r0);
                check("out_im0", o_im0, sb_q[0].i0);
                check("out_re3", o_re3, sb_q[0].r3);
                check("out_im3", o_im3, sb_q[0].i3);
            end
        end
    endtask

    task automatic send_frame(input bit pulse);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        cycle();
        in_valid  = 1'b0;
        while (exp_state == S_RUN) begin
            in_valid = pulse & cyc[0];
            cycle();
        end
        in_valid = 1'b0;
    endtask

    task automatic release_frame(input int hold, input bit pulse);
        out_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            in_valid = pulse & ~cyc[0];
            cycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc_start, pop_start, guard;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        clear_frame();
        cycle();
        cycle();
        rst = 1'b0;

        clear_frame();
        fr_re[0] = 1000;
        send_frame(1'b0);
        check("impulse_re0", get(o_re0, 0), 1000);
        check("impulse_re1", get(o_re0, 1), 1000);
        check("impulse_re2", get(o_re0, 2), 0);
        release_frame(0, 1'b0);

        clear_frame();
        fr_re[8] = 262144;
        send_frame(1'b0);
        check("stage3_re0", get(o_re3, 0), 262144);
        check("stage3_re8", get(o_re3, 8), -262144);
        check("stage3_im", o_im3, '0);
        release_frame(0, 1'b0);

        clear_frame();
        fr_re[0] = 524287;
        fr_re[1] = 524287;
        send_frame(1'b1);
        check("sat_re0", get(o_re0, 0), 524287);
        check("sat_re1", get(o_re0, 1), 1);
        release_frame(5, 1'b1);

        repeat (3) begin
            rand_frame();
            send_frame(1'b1);
            release_frame(2, 1'b0);
        end

        rand_frame();
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        repeat (3) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        rand_frame();
        send_frame(1'b0);
        release_frame(1, 1'b0);

        rand_frame();
        send_frame(1'b0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();

        acc_start     = n_acc;
        pop_start     = n_pop;
        check_spacing = 1'b1;
        last_acc_cyc  = -1;
        in_valid      = 1'b1;
        out_ready     = 1'b1;
        for (int c = 0; c < 50; c++) begin
            rand_frame();
            cycle();
        end
        in_valid      = 1'b0;
        check_spacing = 1'b0;
        guard         = 0;
        while (exp_state != S_IDLE && guard < 40) begin
            cycle();
            guard++;
        end
        out_ready = 1'b0;
        check("b2b_accepts", n_acc - acc_start, 5);
        check("b2b_delivered", n_pop - pop_start, n_acc - acc_start);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
